i2s_playback_tx: RTL and testbench



---
 rtl/i2s_playback_tx.sv | 117 +++++++++++
 tb/tb_i2s_playback_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_playback_tx.sv
// I2S playback transmitter: latches the final left/right samples once per frame and
// serialises them to the codec, generating bclk and pblrc from mclk. All outputs are
// registered and show the decode of the frame counter one mclk late.
//
// Ports:
//   mclk         master clock (256x fs with defaults), the only clock
//   rst          synchronous active-high reset
//   sample_l/r   signed left/right samples, sampled only at the end of each frame
//   mute         when high, zeros are latched in place of the samples
//   bclk         bit clock, 50% duty, MCLK_PER_BCLK mclk periods per bit
//   pblrc        0 = left slot, 1 = right slot
//   pbdat        serial data, MSB first, zero padded, changes on bclk falling edges
//   frame_strobe one-mclk pulse in the cycle the counter wraps to 0 (sample-rate tick)
module i2s_playback_tx #(
  parameter int unsigned SAMPLE_BITS   = 16,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned MCLK_PER_BCLK = 4,
  parameter int unsigned FORMAT        = 0
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] sample_l,
  input  logic [SAMPLE_BITS-1:0] sample_r,
  input  logic                   mute,
  output logic                   bclk,
  output logic                   pblrc,
  output logic                   pbdat,
  output logic                   frame_strobe
);

  localparam int unsigned Frame     = 2 * SLOT_BITS * MCLK_PER_BCLK;
  localparam int unsigned CntW      = $clog2(Frame);
  localparam int unsigned HalfBclk  = MCLK_PER_BCLK / 2;
  // I2S delays the MSB by one bclk after the pblrc edge; left-justified does not.
  localparam int unsigned DataDelay = (FORMAT == 0) ? 1 : 0;

  localparam logic [CntW-1:0]        CntLast = CntW'(Frame - 1);
  localparam logic [SAMPLE_BITS-1:0] MsbMask = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  if (SLOT_BITS < SAMPLE_BITS + 1) begin : gen_bad_slot
    $error("SLOT_BITS must be at least SAMPLE_BITS + 1");
  end
  if ((MCLK_PER_BCLK % 2) != 0 || MCLK_PER_BCLK < 2) begin : gen_bad_div
    $error("MCLK_PER_BCLK must be even and at least 2");
  end

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_BITS-1:0] hold_r_q, hold_r_d;
  logic                   bclk_q, bclk_d;
  logic                   pblrc_q, pblrc_d;
  logic                   pbdat_q, pbdat_d;
  logic                   strobe_q, strobe_d;

  int unsigned            cnt_int;
  int unsigned            bit_idx;
  int unsigned            phase;
  int unsigned            slot_pos;
  logic [SAMPLE_BITS-1:0] word;
  logic                   last_cycle;

  assign cnt_int    = 32'(cnt_q);
  assign bit_idx    = cnt_int / MCLK_PER_BCLK;
  assign phase      = cnt_int % MCLK_PER_BCLK;
  assign slot_pos   = bit_idx % SLOT_BITS;
  assign last_cycle = (cnt_q == CntLast);

  // Counter and sample holds.
  always_comb begin
    cnt_d    = last_cycle ? '0 : cnt_q + 1'b1;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (last_cycle) begin
      hold_l_d = mute ? '0 : sample_l;
      hold_r_d = mute ? '0 : sample_r;
    end
  end

  // Output decode of the current count; registered below, hence one mclk of latency.
  always_comb begin
    bclk_d   = (phase >= HalfBclk);
    pblrc_d  = (bit_idx >= SLOT_BITS);
    word     = pblrc_d ? hold_r_q : hold_l_q;
    pbdat_d  = 1'b0;
    if (slot_pos >= DataDelay && slot_pos < SAMPLE_BITS + DataDelay) begin
      // Walk a single-bit mask down from the MSB instead of a variable bit select.
      pbdat_d = |(word & (MsbMask >> (slot_pos - DataDelay)));
    end
    strobe_d = last_cycle;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_q    <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      bclk_q   <= 1'b0;
      pblrc_q  <= 1'b0;
      pbdat_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      bclk_q   <= bclk_d;
      pblrc_q  <= pblrc_d;
      pbdat_q  <= pbdat_d;
      strobe_q <= strobe_d;
    end
  end

  assign bclk         = bclk_q;
  assign pblrc        = pblrc_q;
  assign pbdat        = pbdat_q;
  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_i2s_playback_tx.sv
// Bench for i2s_playback_tx: one I2S instance and one left-justified instance share
// the inputs. A frame-level reference model (expected slot bit streams per frame) is
// checked every mclk; slot words captured at bclk rising edges are compared against
// hand-computed table entries; hand sequences cover reset, mid-frame changes and mute.
module tb_i2s_playback_tx;

  localparam int FRAME = 256;
  localparam int SLOT  = 32;
  localparam int MPB   = 4;

  logic        mclk = 1'b0;
  logic        rst;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        mute;
  logic        bclk0, pblrc0, pbdat0, frame_strobe0;
  logic        bclk1, pblrc1, pbdat1, frame_strobe1;

  int checks   = 0;
  int failures = 0;

  // Reference model state: counter position and the expected slot streams of the
  // frame in flight (bit 31 = slot position 0).
  int          m_cnt;
  logic [31:0] m_wl0, m_wr0, m_wl1, m_wr1;

  always #5 mclk = ~mclk;

  i2s_playback_tx #(.SAMPLE_BITS(16), .SLOT_BITS(32), .MCLK_PER_BCLK(4), .FORMAT(0)) dut0 (
    .mclk(mclk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r), .mute(mute),
    .bclk(bclk0), .pblrc(pblrc0), .pbdat(pbdat0), .frame_strobe(frame_strobe0)
  );

  i2s_playback_tx #(.SAMPLE_BITS(16), .SLOT_BITS(32), .MCLK_PER_BCLK(4), .FORMAT(1)) dut1 (
    .mclk(mclk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r), .mute(mute),
    .bclk(bclk1), .pblrc(pblrc1), .pbdat(pbdat1), .frame_strobe(frame_strobe1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Slot stream: d leading zeros, the sample MSB first, then zero padding.
  function automatic logic [31:0] slot_word(input logic [15:0] smp, input int d);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[31-d-i] = smp[15-i];
    return w;
  endfunction

  // {bclk, pblrc, pbdat, frame_strobe} expected while frame position pos is on the wire.
  function automatic logic [3:0] expect_out(input int pos, input logic [31:0] wl,
                                            input logic [31:0] wr);
    int   b;
    logic eb, el, ed, es;
    b  = pos / MPB;
    eb = (pos % MPB) >= (MPB / 2);
    el = (b >= SLOT);
    ed = (b < SLOT) ? wl[SLOT-1-b] : wr[2*SLOT-1-b];
    es = (pos == FRAME - 1);
    return {eb, el, ed, es};
  endfunction

  // One mclk: advance the model with the inputs about to be sampled, then compare.
  task automatic tick();
    logic [3:0]  exp0, exp1;
    logic [15:0] nl, nr;
    if (rst) begin
      m_cnt = 0;
      m_wl0 = '0; m_wr0 = '0; m_wl1 = '0; m_wr1 = '0;
      exp0  = '0;
      exp1  = '0;
    end else begin
      exp0 = expect_out(m_cnt, m_wl0, m_wr0);
      exp1 = expect_out(m_cnt, m_wl1, m_wr1);
      if (m_cnt == FRAME - 1) begin
        nl    = mute ? 16'h0 : sample_l;
        nr    = mute ? 16'h0 : sample_r;
        m_wl0 = slot_word(nl, 1);
        m_wr0 = slot_word(nr, 1);
        m_wl1 = slot_word(nl, 0);
        m_wr1 = slot_word(nr, 0);
      end
      m_cnt = (m_cnt + 1) % FRAME;
    end
    @(posedge mclk);
    @(negedge mclk);
    check("cyc_i2s", 32'({bclk0, pblrc0, pbdat0, frame_strobe0}), 32'(exp0));
    check("cyc_lj", 32'({bclk1, pblrc1, pbdat1, frame_strobe1}), 32'(exp1));
  endtask

  // Starts right after a strobe; captures one whole frame at bclk rising edges.
  task automatic capture_frame(input int chg_at, input logic [15:0] nl, input logic [15:0] nr,
                               input logic nm, output logic [31:0] l0, output logic [31:0] r0,
                               output logic [31:0] l1, output logic [31:0] r1);
    int   bi;
    logic prev;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    bi = 0;
    for (int t = 1; t <= FRAME; t++) begin
      if (t == chg_at) begin
        sample_l = nl;
        sample_r = nr;
        mute     = nm;
      end
      prev = bclk0;
      tick();
      if (!prev && bclk0) begin
        if (bi < SLOT) begin
          l0[SLOT-1-bi] = pbdat0;
          l1[SLOT-1-bi] = pbdat1;
        end else if (bi < 2 * SLOT) begin
          r0[2*SLOT-1-bi] = pbdat0;
          r1[2*SLOT-1-bi] = pbdat1;
        end
        bi++;
      end
    end
    check("bclk_rises", 32'(bi), 32'(2 * SLOT));
    check("strobe_align", 32'(frame_strobe0), 32'h1);
  endtask

  task automatic sync_to_strobe();
    int n;
    n = 0;
    while (frame_strobe0 !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check("sync_strobe", 32'(frame_strobe0), 32'h1);
  endtask

  // Counts mclks until the next strobe (-1 if none within the bound).
  task automatic ticks_to_strobe(output int n, output logic any_data);
    int k;
    n        = -1;
    any_data = 1'b0;
    for (k = 1; k <= 2 * FRAME + 10; k++) begin
      tick();
      any_data = any_data | pbdat0 | pbdat1;
      if (frame_strobe0) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        m;
    logic [31:0] el0, er0, el1, er1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          n;
    logic        any;
    logic [31:0] l0, r0, l1, r1;

    vecs[0] = '{16'h8001, 16'h7FFE, 1'b0, 32'h40008000, 32'h3FFF0000, 32'h80010000, 32'h7FFE0000};
    vecs[1] = '{16'h1234, 16'hABCD, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{16'h8000, 16'h7FFF, 1'b0, 32'h40000000, 32'h3FFF8000, 32'h80000000, 32'h7FFF0000};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 32'h7FFF8000, 32'h00008000, 32'hFFFF0000, 32'h00010000};
    vecs[4] = '{16'h00FF, 16'hFF00, 1'b0, 32'h007F8000, 32'h7F800000, 32'h00FF0000, 32'hFF000000};

    // Reset hold, then release with a sample already present.
    rst = 1'b1; sample_l = 16'h1234; sample_r = 16'h0; mute = 1'b0;
    repeat (5) tick();
    check("rst_outputs", 32'({bclk0, pblrc0, pbdat0, frame_strobe0}), 32'h0);
    rst = 1'b0;
    ticks_to_strobe(n, any);
    check("first_strobe_cyc", 32'(n), 32'(FRAME));
    check("frame0_zero", 32'(any), 32'h0);
    ticks_to_strobe(n, any);
    check("strobe_period", 32'(n), 32'(FRAME));

    // Table: the frame after the one that latches the vector carries it.
    foreach (vecs[i]) begin
      sample_l = vecs[i].l; sample_r = vecs[i].r; mute = vecs[i].m;
      sync_to_strobe();
      capture_frame(0, 16'h0, 16'h0, 1'b0, l0, r0, l1, r1);
      capture_frame(0, 16'h0, 16'h0, 1'b0, l0, r0, l1, r1);
      check($sformatf("vec%0d_l_i2s", i), l0, vecs[i].el0);
      check($sformatf("vec%0d_r_i2s", i), r0, vecs[i].er0);
      check($sformatf("vec%0d_l_lj", i), l1, vecs[i].el1);
      check($sformatf("vec%0d_r_lj", i), r1, vecs[i].er1);
    end

    // Mid-frame sample change only affects the following frame.
    sample_l = 16'h00FF; sample_r = 16'h0; mute = 1'b0;
    capture_frame(0, 16'h0, 16'h0, 1'b0, l0, r0, l1, r1);
    capture_frame(101, 16'hFF00, 16'h0, 1'b0, l0, r0, l1, r1);
    check("midchg_cur", l0, 32'h007F8000);
    capture_frame(0, 16'h0, 16'h0, 1'b0, l0, r0, l1, r1);
    check("midchg_next", l0, 32'h7F800000);
    check("midchg_next_lj", l1, 32'hFF000000);

    // Mute takes effect only at the latch point.
    sample_l = 16'h7FFF;
    capture_frame(0, 16'h0, 16'h0, 1'b0, l0, r0, l1, r1);
    capture_frame(10, 16'h7FFF, 16'h0, 1'b1, l0, r0, l1, r1);
    check("mute_cur", l0, 32'h3FFF8000);
    capture_frame(10, 16'h7FFF, 16'h0, 1'b0, l0, r0, l1, r1);
    check("mute_zero", l0 | r0 | l1 | r1, 32'h0);
    capture_frame(0, 16'h0, 16'h0, 1'b0, l0, r0, l1, r1);
    check("mute_restore", l0, 32'h3FFF8000);
    check("mute_restore_lj", l1, 32'h7FFF0000);

    // Single-cycle reset in the middle of the left slot.
    repeat (70) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", 32'({bclk0, pblrc0, pbdat0, frame_strobe0, bclk1, pblrc1,
                                  pbdat1, frame_strobe1}), 32'h0);
    rst = 1'b0;
    ticks_to_strobe(n, any);
    check("rst_mid_strobe", 32'(n), 32'(FRAME));
    check("rst_mid_zero", 32'(any), 32'h0);

    // Randomised traffic against the model, with occasional resets and mute toggles.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) sample_l = 16'($urandom);
      if ($urandom_range(0, 19) == 0) sample_r = 16'($urandom);
      if ($urandom_range(0, 59) == 0) mute = ~mute;
      rst = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1);
  end

endmodule
